// File: rtl/rgb_pwm_driver.sv
// rgb_pwm_driver: boundary-aligned, slew-limited 3-channel PWM for an active-low RGB LED (in_valid/in_ready/in_rgb targets in; settled, period_start, RGB_R/G/B pins out)
module rgb_pwm_driver #(
  parameter int PWM_PERIOD = 1200,
  parameter int DUTY_W = 11,
  parameter int SLEW_DELTA = 1200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DUTY_W-1:0] in_r,
  input  logic [DUTY_W-1:0] in_g,
  input  logic [DUTY_W-1:0] in_b,
  output logic              settled,
  output logic              period_start,
  output logic              RGB_R,
  output logic              RGB_G,
  output logic              RGB_B
);
  localparam logic [DUTY_W-1:0] MAX = DUTY_W'(PWM_PERIOD);
  localparam logic [DUTY_W-1:0] LAST = DUTY_W'(PWM_PERIOD - 1);
  localparam logic [DUTY_W-1:0] SD = DUTY_W'(SLEW_DELTA >= PWM_PERIOD ? PWM_PERIOD : SLEW_DELTA);
  logic rst_q, pend_v, pend_v_n, boundary, accept;
  logic [DUTY_W-1:0] cnt, cnt_n;
  logic [2:0][DUTY_W-1:0] pend, tgt, app, in_c, tgt_n, app_n;
  assign boundary = !rst_q && cnt == LAST;
  assign in_ready = !rst_q && (!pend_v || boundary);
  assign accept = in_valid && in_ready;
  assign pend_v_n = accept || (pend_v && !boundary);
  assign cnt_n = rst_q || boundary ? '0 : cnt + 1'b1;
  always_comb begin
    in_c[0] = in_r > MAX ? MAX : in_r;
    in_c[1] = in_g > MAX ? MAX : in_g;
    in_c[2] = in_b > MAX ? MAX : in_b;
    tgt_n = boundary && pend_v ? pend : tgt;
    for (int c = 0; c < 3; c++)
      app_n[c] = !boundary ? app[c] :
                 tgt_n[c] >= app[c] ? (tgt_n[c] - app[c] <= SD ? tgt_n[c] : app[c] + SD) :
                                      (app[c] - tgt_n[c] <= SD ? tgt_n[c] : app[c] - SD);
  end
  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst) begin
      cnt <= '0;
      pend_v <= 1'b0;
      pend <= '0;
      tgt <= '0;
      app <= '0;
      {RGB_B, RGB_G, RGB_R} <= 3'b111;
      settled <= 1'b1;
      period_start <= 1'b0;
    end else begin
      cnt <= cnt_n;
      period_start <= cnt_n == '0;
      pend_v <= pend_v_n;
      if (accept) pend <= in_c;
      tgt <= tgt_n;
      app <= app_n;
      RGB_R <= !(cnt < app[0]);
      RGB_G <= !(cnt < app[1]);
      RGB_B <= !(cnt < app[2]);
      settled <= tgt_n == app_n && !pend_v_n;
    end
  end
endmodule

// File: tb/tb_rgb_pwm_driver.sv
// tb_rgb_pwm_driver: randomized self-checking bench for rgb_pwm_driver (immediate and slewed instances)
module tb_rgb_pwm_driver;
  localparam int P = 1200, W = 11, SF = 1200, SS = 100;
  logic clk = 0, rst = 1, in_valid = 0;
  logic [W-1:0] in_r = 0, in_g = 0, in_b = 0;
  logic rdy_f, rdy_s, st_f, st_s, ps_f, ps_s, rf, gf, bf, rs, gs, bs;
  int tests = 0, fails = 0;
  bit m_rq = 1, m_pv, m_bnd, m_rdy;
  int m_cnt, m_p[3], m_tgt[3], m_af[3], m_as[3];
  int got_tot[6], got_run[6], want[6];
  logic got_st[2];
  bit want_st[2];
  string nm[6] = '{"R_fast", "G_fast", "B_fast", "R_slow", "G_slow", "B_slow"};

  always #5 clk = ~clk;

  rgb_pwm_driver #(.PWM_PERIOD(P), .DUTY_W(W), .SLEW_DELTA(SF)) dut_f (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_f), .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .settled(st_f), .period_start(ps_f), .RGB_R(rf), .RGB_G(gf), .RGB_B(bf));
  rgb_pwm_driver #(.PWM_PERIOD(P), .DUTY_W(W), .SLEW_DELTA(SS)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_s), .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .settled(st_s), .period_start(ps_s), .RGB_R(rs), .RGB_G(gs), .RGB_B(bs));

  function automatic int clamp(int v);
    return v > P ? P : v;
  endfunction

  function automatic int step(int a, int t, int s);
    return t > a ? (a + s < t ? a + s : t) : (a - s > t ? a - s : t);
  endfunction

  function automatic bit m_settled(bit slow);
    for (int c = 0; c < 3; c++) if ((slow ? m_as[c] : m_af[c]) != m_tgt[c]) return 0;
    return !m_pv;
  endfunction

  // Reference: one buffered update slot, retargeting and slewing once per period.
  always @(posedge clk) begin
    if (rst) begin
      m_rq = 1; m_cnt = 0; m_pv = 0;
      m_tgt = '{0, 0, 0}; m_af = '{0, 0, 0}; m_as = '{0, 0, 0};
    end else begin
      m_bnd = !m_rq && m_cnt == P - 1;
      m_rdy = !m_rq && (!m_pv || m_bnd);
      if (m_bnd) begin
        if (m_pv) m_tgt = m_p;
        m_pv = 0;
        for (int c = 0; c < 3; c++) begin
          m_af[c] = step(m_af[c], m_tgt[c], SF);
          m_as[c] = step(m_as[c], m_tgt[c], SS);
        end
      end
      if (in_valid && m_rdy) begin
        m_p = '{clamp(int'(in_r)), clamp(int'(in_g)), clamp(int'(in_b))};
        m_pv = 1;
      end
      m_cnt = m_rq ? 0 : (m_cnt + 1) % P;
      m_rq = 0;
    end
  end

  task automatic send(input int r, input int g, input int b);
    int n = 0;
    in_valid = 1; in_r = W'(r); in_g = W'(g); in_b = W'(b);
    while (rdy_f !== 1'b1 && n < 3 * P) begin @(negedge clk); n++; end
    if (rdy_f !== 1'b1) begin tests++; fails++; $display("FAIL send_timeout: in_ready=%b want 1", rdy_f); end
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
  endtask

  // Waits for period_start, then records the P pin samples that belong to that period.
  task automatic measure_period();
    int n = 0;
    logic [5:0] p;
    bit open[6];
    while (ps_f !== 1'b1 && n < 2 * P) begin @(negedge clk); n++; end
    if (ps_f !== 1'b1) begin tests++; fails++; $display("FAIL period_start_timeout: got %b want 1", ps_f); end
    for (int i = 0; i < 6; i++) begin
      want[i] = i < 3 ? m_af[i] : m_as[i - 3];
      got_tot[i] = 0; got_run[i] = 0; open[i] = 1;
    end
    want_st[0] = m_settled(0); want_st[1] = m_settled(1);
    got_st[0] = st_f; got_st[1] = st_s;
    repeat (P) begin
      @(negedge clk);
      p = {bs, gs, rs, bf, gf, rf};
      for (int i = 0; i < 6; i++)
        if (p[i] === 1'b0) begin got_tot[i]++; if (open[i]) got_run[i]++; end
        else open[i] = 0;
    end
  endtask

  task automatic test_reset();
    rst = 1; in_valid = 0;
    repeat (3) @(negedge clk);
    tests++; if ({rf, gf, bf, rs, gs, bs} !== 6'h3f) begin fails++; $display("FAIL reset_pins: got %b want 111111", {rf, gf, bf, rs, gs, bs}); end
    tests++; if ({st_f, st_s} !== 2'b11) begin fails++; $display("FAIL reset_settled: got %b want 11", {st_f, st_s}); end
    tests++; if ({rdy_f, rdy_s, ps_f, ps_s} !== 4'b0) begin fails++; $display("FAIL reset_ready_ps: got %b want 0000", {rdy_f, rdy_s, ps_f, ps_s}); end
    rst = 0;
    @(negedge clk);
    tests++; if ({rdy_f, rdy_s} !== 2'b11) begin fails++; $display("FAIL release_ready: got %b want 11", {rdy_f, rdy_s}); end
    tests++; if ({ps_f, ps_s} !== 2'b11) begin fails++; $display("FAIL release_cnt0: period_start got %b want 11", {ps_f, ps_s}); end
  endtask

  task automatic test_immediate();
    int w = $urandom_range(1, 600);
    repeat (w) @(negedge clk);
    send(300, 0, 1200);
    tests++; if (rdy_f !== 1'b0) begin fails++; $display("FAIL imm_ready_pending: got %b want 0", rdy_f); end
    tests++; if (st_f !== 1'b0) begin fails++; $display("FAIL imm_settled_pending: got %b want 0", st_f); end
    measure_period();
    for (int i = 0; i < 6; i++) begin tests++; if (got_tot[i] !== want[i] || got_run[i] !== want[i]) begin fails++; $display("FAIL imm_%s: got %0d low (%0d leading) want %0d", nm[i], got_tot[i], got_run[i], want[i]); end end
    for (int i = 0; i < 2; i++) begin tests++; if (got_st[i] !== want_st[i]) begin fails++; $display("FAIL imm_settled%0d: got %b want %b", i, got_st[i], want_st[i]); end end
    tests++; if (got_run[0] !== 300 || got_tot[1] !== 0 || got_run[2] !== 1200 || got_st[0] !== 1'b1)
      begin fails++; $display("FAIL imm_values: got R=%0d G=%0d B=%0d st=%b want 300 0 1200 1", got_run[0], got_tot[1], got_run[2], got_st[0]); end
  endtask

  task automatic test_backpressure();
    int n = 0;
    int exp_r[2] = '{100, 900};
    repeat (10) @(negedge clk);
    in_valid = 1; in_r = 100; in_g = W'($urandom_range(0, 2047)); in_b = W'($urandom_range(0, 2047));
    tests++; if (rdy_f !== 1'b1) begin fails++; $display("FAIL bp_ready_at10: got %b want 1", rdy_f); end
    @(posedge clk);
    @(negedge clk);
    tests++; if ({rdy_f, rdy_s} !== 2'b00) begin fails++; $display("FAIL bp_ready_at11: got %b want 00", {rdy_f, rdy_s}); end
    in_r = 900; in_g = W'($urandom_range(0, 2047)); in_b = W'($urandom_range(0, 2047));
    while (rdy_f !== 1'b1 && n < 2 * P) begin @(negedge clk); n++; end
    tests++; if (n !== P - 12) begin fails++; $display("FAIL bp_stall_len: got %0d want %0d", n, P - 12); end
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    for (int k = 0; k < 2; k++) begin
      measure_period();
      for (int i = 0; i < 6; i++) begin tests++; if (got_tot[i] !== want[i] || got_run[i] !== want[i]) begin fails++; $display("FAIL bp%0d_%s: got %0d low (%0d leading) want %0d", k, nm[i], got_tot[i], got_run[i], want[i]); end end
      for (int i = 0; i < 2; i++) begin tests++; if (got_st[i] !== want_st[i]) begin fails++; $display("FAIL bp%0d_settled%0d: got %b want %b", k, i, got_st[i], want_st[i]); end end
      tests++; if (got_run[0] !== exp_r[k]) begin fails++; $display("FAIL bp%0d_R: got %0d want %0d", k, got_run[0], exp_r[k]); end
    end
  endtask

  task automatic test_clamp();
    int gv[2] = '{2047, 1};
    int ge[2] = '{1200, 1};
    for (int k = 0; k < 2; k++) begin
      repeat (5) @(negedge clk);
      send($urandom_range(0, 1200), gv[k], $urandom_range(0, 1200));
      measure_period();
      for (int i = 0; i < 6; i++) begin tests++; if (got_tot[i] !== want[i] || got_run[i] !== want[i]) begin fails++; $display("FAIL clamp%0d_%s: got %0d low (%0d leading) want %0d", k, nm[i], got_tot[i], got_run[i], want[i]); end end
      tests++; if (got_tot[1] !== ge[k] || got_run[1] !== ge[k]) begin fails++; $display("FAIL clamp%0d_G: got %0d low want %0d", k, got_tot[1], ge[k]); end
    end
  endtask

  task automatic test_reset_mid();
    int w = $urandom_range(100, 900);
    repeat (5) @(negedge clk);
    send(600, 600, 600);
    measure_period();
    tests++; if (got_run[0] !== 600 || got_run[1] !== 600 || got_run[2] !== 600) begin fails++; $display("FAIL rm_pre: got %0d %0d %0d want 600", got_run[0], got_run[1], got_run[2]); end
    repeat (w) @(negedge clk);
    rst = 1;
    @(negedge clk);
    tests++; if ({rf, gf, bf, rs, gs, bs} !== 6'h3f) begin fails++; $display("FAIL rm_pins: got %b want 111111", {rf, gf, bf, rs, gs, bs}); end
    tests++; if ({st_f, st_s, rdy_f, rdy_s} !== 4'b1100) begin fails++; $display("FAIL rm_settled_ready: got %b want 1100", {st_f, st_s, rdy_f, rdy_s}); end
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    tests++; if ({rdy_f, ps_f} !== 2'b11) begin fails++; $display("FAIL rm_release: ready/ps got %b want 11", {rdy_f, ps_f}); end
    measure_period();
    for (int i = 0; i < 6; i++) begin tests++; if (got_tot[i] !== 0 || got_tot[i] !== want[i]) begin fails++; $display("FAIL rm_after_%s: got %0d low want 0 (model %0d)", nm[i], got_tot[i], want[i]); end end
  endtask

  task automatic test_slew();
    int tr[2] = '{350, 0};
    int seq[2][4] = '{'{100, 200, 300, 350}, '{250, 150, 50, 0}};
    for (int d = 0; d < 2; d++) begin
      repeat (5) @(negedge clk);
      send(tr[d], 0, 0);
      for (int k = 0; k < 4; k++) begin
        measure_period();
        for (int i = 0; i < 6; i++) begin tests++; if (got_tot[i] !== want[i] || got_run[i] !== want[i]) begin fails++; $display("FAIL slew%0d_%0d_%s: got %0d low (%0d leading) want %0d", d, k, nm[i], got_tot[i], got_run[i], want[i]); end end
        tests++; if (got_run[3] !== seq[d][k]) begin fails++; $display("FAIL slew%0d_%0d_R: got %0d want %0d", d, k, got_run[3], seq[d][k]); end
        tests++; if (got_st[1] !== (k == 3)) begin fails++; $display("FAIL slew%0d_%0d_settled: got %b want %b", d, k, got_st[1], k == 3); end
      end
    end
  endtask

  task automatic test_reset_mid_slew();
    int w = $urandom_range(100, 900);
    int pre[2] = '{100, 200};
    repeat (5) @(negedge clk);
    send(350, 0, 0);
    for (int k = 0; k < 2; k++) begin
      measure_period();
      tests++; if (got_run[3] !== pre[k]) begin fails++; $display("FAIL rms_pre%0d: got %0d want %0d", k, got_run[3], pre[k]); end
    end
    repeat (w) @(negedge clk);
    rst = 1;
    @(negedge clk);
    tests++; if ({rf, gf, bf, rs, gs, bs} !== 6'h3f) begin fails++; $display("FAIL rms_pins: got %b want 111111", {rf, gf, bf, rs, gs, bs}); end
    tests++; if ({st_s, rdy_s} !== 2'b10) begin fails++; $display("FAIL rms_settled_ready: got %b want 10", {st_s, rdy_s}); end
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    tests++; if (rdy_s !== 1'b1) begin fails++; $display("FAIL rms_release_ready: got %b want 1", rdy_s); end
    for (int k = 0; k < 2; k++) begin
      measure_period();
      for (int i = 0; i < 6; i++) begin tests++; if (got_tot[i] !== 0 || got_tot[i] !== want[i]) begin fails++; $display("FAIL rms_after%0d_%s: got %0d low want 0 (model %0d)", k, nm[i], got_tot[i], want[i]); end end
      tests++; if (got_st[1] !== 1'b1) begin fails++; $display("FAIL rms_after%0d_settled: got %b want 1", k, got_st[1]); end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 5; k++) begin
      int w = $urandom_range(0, 1300);
      repeat (w) @(negedge clk);
      send($urandom_range(0, 2047), $urandom_range(0, 2047), $urandom_range(0, 2047));
      measure_period();
      for (int i = 0; i < 6; i++) begin tests++; if (got_tot[i] !== want[i] || got_run[i] !== want[i]) begin fails++; $display("FAIL rand%0d_%s: got %0d low (%0d leading) want %0d", k, nm[i], got_tot[i], got_run[i], want[i]); end end
      for (int i = 0; i < 2; i++) begin tests++; if (got_st[i] !== want_st[i]) begin fails++; $display("FAIL rand%0d_settled%0d: got %b want %b", k, i, got_st[i], want_st[i]); end end
    end
  endtask

  initial begin
    test_reset();
    test_immediate();
    test_backpressure();
    test_clamp();
    test_reset_mid();
    test_slew();
    test_reset_mid_slew();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
